program_memory: RTL and testbench
=================================

PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, 10, fetch address width in bits.
REQ-003 SHALL have parameter DEPTH, 64, number of stored words; DEPTH <= 2^ADDR_WIDTH.
REQ-004 SHALL have parameter NOP_WORD, all zeros, word returned on empty or invalid fetch.
REQ-005 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port load_start  input  1  begin a new program load.
REQ-008 SHALL have port load_valid  input  1  load_data holds a word to store.
REQ-009 SHALL have port load_data  input  DATA_WIDTH  program word.
REQ-010 SHALL have port load_done  input  1  end the current load.
REQ-011 SHALL have port load_ready  output  1  a word will be accepted this cycle.
REQ-012 SHALL have port load_overflow  output  1  sticky: a word was dropped because memory was full.
REQ-013 SHALL have port program_size  output  clog2(DEPTH+1)  count of valid program words.
REQ-014 SHALL have port mem_ready  output  1  state is RUN.
REQ-015 SHALL have port fetch_req  input  1  fetch request.
REQ-016 SHALL have port fetch_addr  input  ADDR_WIDTH  word address.
REQ-017 SHALL have port fetch_valid  output  1  instruction_out is valid.
REQ-018 SHALL have port instruction_out  output  DATA_WIDTH  fetched word.
REQ-019 SHALL have port addr_fault  output  1  fetched address was at or beyond program_size.

Function
REQ-020 SHALL implement states EMPTY, LOAD and RUN.
REQ-021 SHALL move from EMPTY or RUN to LOAD on load_start, clearing the write pointer, program_size and load_overflow.
REQ-022 SHALL restart the load from pointer 0 if load_start is asserted while in LOAD.
REQ-023 SHALL, in LOAD, write load_data to mem[pointer] and increment the pointer when load_valid and load_ready are both high.
REQ-024 SHALL drive load_ready high only in LOAD with pointer < DEPTH.
REQ-025 SHALL drop a load_valid word arriving at pointer == DEPTH and set load_overflow until the next load_start or reset.
REQ-026 SHALL, on load_done in LOAD, move to RUN with program_size equal to the number of words accepted, including a word accepted in the same cycle.
REQ-027 SHALL give load_start priority over load_done when both are asserted in the same cycle.
REQ-028 SHALL ignore load_valid and load_done outside LOAD.
REQ-029 SHALL produce a fetch response exactly one cycle after fetch_req, with registered fetch_valid, instruction_out and addr_fault.
REQ-030 SHALL accept one fetch per cycle, fully pipelined, with no back-pressure.
REQ-031 SHALL, in RUN, return mem[fetch_addr] with addr_fault=0 when fetch_addr < program_size.
REQ-032 SHALL, in RUN, return NOP_WORD with addr_fault=1 when fetch_addr >= program_size; no wrap-around.
REQ-033 SHALL, in EMPTY, answer fetch_req with fetch_valid=1, NOP_WORD and addr_fault=1.
REQ-034 SHALL, in LOAD, ignore fetch_req; the next cycle gives fetch_valid=0.
REQ-035 SHALL hold instruction_out and addr_fault between fetches, and drive fetch_valid=0 in cycles without an accepted request.
REQ-036 SHALL not require memory contents to be cleared; validity is defined solely by program_size.

Reset
REQ-037 SHALL, on reset low at any time including mid-load, immediately enter EMPTY.
REQ-038 SHALL drive the following reset values: program_size=0, pointer=0, load_ready=0, load_overflow=0, mem_ready=0, fetch_valid=0, instruction_out=NOP_WORD, addr_fault=0.
REQ-039 SHALL resume normal operation on the first rising clock edge after reset deasserts.

Verification
REQ-040 SHALL verify that after reset, fetch_req with addr 0 gives, next cycle, fetch_valid=1, instruction_out=0 and addr_fault=1.
REQ-041 SHALL verify load_start, then 3 words 0x30060000, 0x30070001, 0x7C010000, then load_done: mem_ready=1, program_size=3; fetches of addr 0,1,2 on consecutive cycles return those words on the following cycles with addr_fault=0.
REQ-042 SHALL verify, with DEPTH=4, a load of 5 words: the fifth is dropped, load_overflow=1, load_ready=0, and after load_done program_size=4.
REQ-043 SHALL verify that with program_size=3, a fetch of addr 3 and a fetch of addr 1023 each return NOP_WORD with addr_fault=1.
REQ-044 SHALL verify that reset asserted after 2 of 5 load words gives EMPTY, program_size=0, and fetch addr 0 returns NOP_WORD with fault.
REQ-045 SHALL verify that load_valid with load_done in the same cycle, as the 2nd word, gives program_size=2 and that word fetchable; load_start with load_done in the same cycle stays in LOAD with pointer 0.

Source files
------------

// File: rtl/program_memory.sv
// Loadable program store: words are streamed in during LOAD, then fetched in RUN
// with a one-cycle registered response and an address-fault flag.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | no program; every fetch answers NOP_WORD with a fault
// ST_LOAD  | accepting words at the write pointer; fetches are ignored
// ST_RUN   | program_size words valid; fetches served from memory
module program_memory #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           load_start,
    input  logic                           load_valid,
    input  logic [DATA_WIDTH-1:0]          load_data,
    input  logic                           load_done,
    output logic                           load_ready,
    output logic                           load_overflow,
    output logic [$clog2(DEPTH+1)-1:0]     program_size,
    output logic                           mem_ready,
    input  logic                           fetch_req,
    input  logic [ADDR_WIDTH-1:0]          fetch_addr,
    output logic                           fetch_valid,
    output logic [DATA_WIDTH-1:0]          instruction_out,
    output logic                           addr_fault
);

    localparam int PSW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PSW-1:0]        ptr_q, ptr_d;
    logic [PSW-1:0]        size_q, size_d;
    logic                  ovf_q, ovf_d;
    logic                  fvalid_q, fvalid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  fault_q, fault_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready;
    logic                  wr_en;
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         rd_idx;
    logic                  in_range;

    assign ready    = (state_q == ST_LOAD) && (ptr_q < PSW'(DEPTH));
    assign wr_idx   = IW'(ptr_q);
    assign rd_idx   = IW'(fetch_addr);
    // Widen both sides so an address beyond DEPTH never aliases into range.
    assign in_range = 32'(fetch_addr) < 32'(size_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        size_d  = size_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;

        if (load_start) begin
            state_d = ST_LOAD;
            ptr_d   = '0;
            size_d  = '0;
            ovf_d   = 1'b0;
        end else if (state_q == ST_LOAD) begin
            if (load_valid && ready) begin
                wr_en = 1'b1;
                ptr_d = ptr_q + PSW'(1);
            end else if (load_valid) begin
                ovf_d = 1'b1;
            end
            if (load_done) begin
                state_d = ST_RUN;
                size_d  = ptr_d;
            end
        end
    end

    always_comb begin
        fvalid_d = 1'b0;
        instr_d  = instr_q;
        fault_d  = fault_q;
        if (fetch_req) begin
            case (state_q)
                ST_EMPTY: begin
                    fvalid_d = 1'b1;
                    instr_d  = NOP_WORD;
                    fault_d  = 1'b1;
                end
                ST_RUN: begin
                    fvalid_d = 1'b1;
                    instr_d  = in_range ? mem[rd_idx] : NOP_WORD;
                    fault_d  = !in_range;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_EMPTY;
            ptr_q    <= '0;
            size_q   <= '0;
            ovf_q    <= 1'b0;
            fvalid_q <= 1'b0;
            instr_q  <= NOP_WORD;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            size_q   <= size_d;
            ovf_q    <= ovf_d;
            fvalid_q <= fvalid_d;
            instr_q  <= instr_d;
            fault_q  <= fault_d;
        end
    end

    // Storage is never cleared; program_size alone decides which words are valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= load_data;
        end
    end

    assign load_ready      = ready;
    assign load_overflow   = ovf_q;
    assign program_size    = size_q;
    assign mem_ready       = (state_q == ST_RUN);
    assign fetch_valid     = fvalid_q;
    assign instruction_out = instr_q;
    assign addr_fault      = fault_q;

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory (DEPTH=4) with hand-computed expectations.
module tb_program_memory;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int DP = 4;
    localparam int SW = $clog2(DP + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          load_start, load_valid, load_done;
    logic [DW-1:0] load_data;
    logic          load_ready, load_overflow, mem_ready;
    logic [SW-1:0] program_size;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_valid, addr_fault;
    logic [DW-1:0] instruction_out;

    int checks = 0;
    int errors = 0;

    program_memory #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DP),
        .NOP_WORD  ('0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .load_start     (load_start),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_done      (load_done),
        .load_ready     (load_ready),
        .load_overflow  (load_overflow),
        .program_size   (program_size),
        .mem_ready      (mem_ready),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_valid    (fetch_valid),
        .instruction_out(instruction_out),
        .addr_fault     (addr_fault)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fetch_chk(input string tag, input logic [AW-1:0] addr,
                             input logic [DW-1:0] exp_word, input logic exp_fault);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        tick();
        fetch_req  = 1'b0;
        chk({tag, "_valid"}, 64'(fetch_valid), 64'd1);
        chk({tag, "_word"},  64'(instruction_out), 64'(exp_word));
        chk({tag, "_fault"}, 64'(addr_fault), 64'(exp_fault));
    endtask

    task automatic push(input logic [DW-1:0] w);
        load_valid = 1'b1;
        load_data  = w;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_done = 1'b0;
        load_data = '0; fetch_req = 1'b0; fetch_addr = '0;
        #3;
        chk("rst_mem_ready", 64'(mem_ready), 64'd0);
        chk("rst_size",      64'(program_size), 64'd0);
        chk("rst_ready",     64'(load_ready), 64'd0);
        chk("rst_ovf",       64'(load_overflow), 64'd0);
        chk("rst_fvalid",    64'(fetch_valid), 64'd0);
        chk("rst_instr",     64'(instruction_out), 64'd0);
        chk("rst_fault",     64'(addr_fault), 64'd0);
        #4 reset = 1'b1;
        tick();

        // fetch while EMPTY
        fetch_chk("empty_f0", 10'd0, 32'h0, 1'b1);
        tick();
        chk("idle_fvalid", 64'(fetch_valid), 64'd0);
        chk("idle_fault_held", 64'(addr_fault), 64'd1);

        // three-word program, consecutive fetches
        load_start = 1'b1; tick(); load_start = 1'b0;
        chk("load_ready_on", 64'(load_ready), 64'd1);
        chk("load_not_run",  64'(mem_ready), 64'd0);
        load_valid = 1'b1;
        load_data = 32'h3006_0000; tick();
        load_data = 32'h3007_0001; tick();
        load_data = 32'h7C01_0000; tick();
        load_valid = 1'b0;
        load_done = 1'b1; tick(); load_done = 1'b0;
        chk("p3_mem_ready", 64'(mem_ready), 64'd1);
        chk("p3_size",      64'(program_size), 64'd3);
        chk("p3_ready_off", 64'(load_ready), 64'd0);
        fetch_req = 1'b1;
        fetch_addr = 10'd0; tick();
        chk("pipe0_valid", 64'(fetch_valid), 64'd1);
        chk("pipe0_word",  64'(instruction_out), 64'h3006_0000);
        chk("pipe0_fault", 64'(addr_fault), 64'd0);
        fetch_addr = 10'd1; tick();
        chk("pipe1_word",  64'(instruction_out), 64'h3007_0001);
        chk("pipe1_fault", 64'(addr_fault), 64'd0);
        fetch_addr = 10'd2; tick();
        chk("pipe2_word",  64'(instruction_out), 64'h7C01_0000);
        chk("pipe2_valid", 64'(fetch_valid), 64'd1);
        fetch_req = 1'b0; tick();
        chk("hold_fvalid", 64'(fetch_valid), 64'd0);
        chk("hold_word",   64'(instruction_out), 64'h7C01_0000);

        // out-of-range fetches
        fetch_chk("oor3",    10'd3,    32'h0, 1'b1);
        fetch_chk("oor1023", 10'd1023, 32'h0, 1'b1);
        fetch_chk("back0",   10'd0,    32'h3006_0000, 1'b0);

        // overflow with DEPTH=4
        load_start = 1'b1; tick(); load_start = 1'b0;
        chk("ov_size_clr", 64'(program_size), 64'd0);
        push(32'hA0); push(32'hA1); push(32'hA2);
        chk("ov_ready3", 64'(load_ready), 64'd1);
        push(32'hA3);
        chk("ov_ready_full", 64'(load_ready), 64'd0);
        chk("ov_flag_pre",   64'(load_overflow), 64'd0);
        push(32'hDEAD);
        chk("ov_flag",       64'(load_overflow), 64'd1);
        chk("ov_ready_drop", 64'(load_ready), 64'd0);
        load_done = 1'b1; tick(); load_done = 1'b0;
        chk("ov_size",       64'(program_size), 64'd4);
        chk("ov_flag_stick", 64'(load_overflow), 64'd1);
        fetch_chk("ov_f3", 10'd3, 32'hA3, 1'b0);
        fetch_chk("ov_f4", 10'd4, 32'h0, 1'b1);

        // fetch ignored in LOAD, then reset mid-load
        load_start = 1'b1; tick(); load_start = 1'b0;
        chk("ld_ovf_clr", 64'(load_overflow), 64'd0);
        fetch_req = 1'b1; fetch_addr = 10'd0;
        push(32'hB0);
        fetch_req = 1'b0;
        chk("ld_fetch_ign", 64'(fetch_valid), 64'd0);
        push(32'hB1);
        load_valid = 1'b1; load_data = 32'hB2;
        reset = 1'b0; #1;
        chk("mid_rst_run",   64'(mem_ready), 64'd0);
        chk("mid_rst_size",  64'(program_size), 64'd0);
        chk("mid_rst_ready", 64'(load_ready), 64'd0);
        load_valid = 1'b0;
        #2 reset = 1'b1;
        tick();
        fetch_chk("mid_rst_f0", 10'd0, 32'h0, 1'b1);

        // word + done in same cycle
        load_start = 1'b1; tick(); load_start = 1'b0;
        push(32'hC0);
        load_valid = 1'b1; load_data = 32'hC1; load_done = 1'b1;
        tick();
        load_valid = 1'b0; load_done = 1'b0;
        chk("vd_size", 64'(program_size), 64'd2);
        chk("vd_run",  64'(mem_ready), 64'd1);
        fetch_chk("vd_f1", 10'd1, 32'hC1, 1'b0);
        fetch_chk("vd_f2", 10'd2, 32'h0, 1'b1);

        // start + done together: start wins, pointer restarts
        load_start = 1'b1; load_done = 1'b1; tick();
        load_start = 1'b0; load_done = 1'b0;
        chk("sd_run",   64'(mem_ready), 64'd0);
        chk("sd_ready", 64'(load_ready), 64'd1);
        chk("sd_size",  64'(program_size), 64'd0);
        push(32'hE0); push(32'hE1);
        load_start = 1'b1; tick(); load_start = 1'b0;
        push(32'hD0);
        load_done = 1'b1; tick(); load_done = 1'b0;
        chk("restart_size", 64'(program_size), 64'd1);
        fetch_chk("restart_f0", 10'd0, 32'hD0, 1'b0);
        fetch_chk("restart_f1", 10'd1, 32'h0, 1'b1);

        // load_valid/load_done ignored in RUN
        load_valid = 1'b1; load_data = 32'hFF; load_done = 1'b1; tick();
        load_valid = 1'b0; load_done = 1'b0;
        chk("run_ign_size", 64'(program_size), 64'd1);
        chk("run_ign_run",  64'(mem_ready), 64'd1);
        chk("run_ign_ovf",  64'(load_overflow), 64'd0);
        fetch_chk("run_ign_f0", 10'd0, 32'hD0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
